// File: rtl/change_dispenser_if.sv
// change_dispenser_if: vend request, refill and coin-eject signals between the vending FSM and the dispenser
interface change_dispenser_if;
  logic       vend;
  logic [2:0] change_in;
  logic       refill_1;
  logic       refill_2;
  logic       eject_1;
  logic       eject_2;
  logic       busy;
  logic       done;
  logic [2:0] shortfall;
  logic       short;
  logic [3:0] tube1_cnt;
  logic [3:0] tube2_cnt;
  logic       overrun;
  modport master (
    output vend, change_in, refill_1, refill_2,
    input  eject_1, eject_2, busy, done, shortfall, short, tube1_cnt, tube2_cnt, overrun
  );
  modport slave (
    input  vend, change_in, refill_1, refill_2,
    output eject_1, eject_2, busy, done, shortfall, short, tube1_cnt, tube2_cnt, overrun
  );
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser: pays change as 2-unit-first coin-eject pulses from two stock-tracked tubes
module change_dispenser #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int TUBE_INIT    = 8
) (
  input logic clk,
  input logic rst,
  change_dispenser_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_t;
  localparam int CW = $clog2((PULSE_CYCLES > GAP_CYCLES ? PULSE_CYCLES : GAP_CYCLES) + 1);
  localparam logic [CW-1:0] P_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] G_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [3:0] T_INIT = 4'(TUBE_INIT);
  state_t state_q, state_d;
  logic [2:0] rem_q, rem_d, shortfall_q, shortfall_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] tube1_q, tube1_d, tube2_q, tube2_d;
  logic coin2_q, coin2_d, vend_q, overrun_q, overrun_d, req, dec1, dec2;
  assign req = bus.vend & ~vend_q;
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    coin2_d = coin2_q;
    cnt_d = cnt_q;
    shortfall_d = shortfall_q;
    dec1 = 1'b0;
    dec2 = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        rem_d = bus.change_in;
        state_d = bus.change_in != 3'd0 ? SELECT : DONE;
      end
      SELECT: begin
        cnt_d = '0;
        if (rem_q >= 3'd2 && tube2_q != 4'd0) begin
          rem_d = rem_q - 3'd2;
          dec2 = 1'b1;
          coin2_d = 1'b1;
          state_d = PULSE;
        end else if (rem_q != 3'd0 && tube1_q != 4'd0) begin
          rem_d = rem_q - 3'd1;
          dec1 = 1'b1;
          coin2_d = 1'b0;
          state_d = PULSE;
        end else state_d = DONE;
      end
      PULSE: begin
        cnt_d = cnt_q == P_LAST ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == P_LAST ? GAP : PULSE;
      end
      GAP: begin
        cnt_d = cnt_q == G_LAST ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == G_LAST ? SELECT : GAP;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // shortfall is captured on entry so it is already visible during the done cycle
    if (state_d == DONE) shortfall_d = rem_d;
  end
  always_comb begin
    tube1_d = (dec1 == bus.refill_1) ? tube1_q : dec1 ? tube1_q - 4'd1 : (tube1_q == 4'd15 ? tube1_q : tube1_q + 4'd1);
    tube2_d = (dec2 == bus.refill_2) ? tube2_q : dec2 ? tube2_q - 4'd1 : (tube2_q == 4'd15 ? tube2_q : tube2_q + 4'd1);
    overrun_d = overrun_q | (req & (state_q != IDLE));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q <= '0;
      shortfall_q <= '0;
      cnt_q <= '0;
      coin2_q <= 1'b0;
      tube1_q <= T_INIT;
      tube2_q <= T_INIT;
      vend_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      shortfall_q <= shortfall_d;
      cnt_q <= cnt_d;
      coin2_q <= coin2_d;
      tube1_q <= tube1_d;
      tube2_q <= tube2_d;
      vend_q <= bus.vend;
      overrun_q <= overrun_d;
    end
  end
  assign bus.eject_1 = (state_q == PULSE) & ~coin2_q;
  assign bus.eject_2 = (state_q == PULSE) & coin2_q;
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
  assign bus.shortfall = shortfall_q;
  assign bus.short = |shortfall_q;
  assign bus.tube1_cnt = tube1_q;
  assign bus.tube2_cnt = tube2_q;
  assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed scenarios with hand-computed eject/done traces for change_dispenser
module tb_change_dispenser;
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] e1_tr, e2_tr, dn_tr;
  logic [2:0] sf_seen;
  logic sh_seen, both_seen;
  change_dispenser_if cd();
  change_dispenser dut (.clk(clk), .rst(rst), .bus(cd));
  always #5 clk = ~clk;
  // cycle k of the trace is the k-th cycle after the vend edge cycle
  task automatic run(input logic [2:0] c, input int n, input int r2_cyc, input int v2_cyc, input int rst_cyc);
    e1_tr = '0; e2_tr = '0; dn_tr = '0; sf_seen = '0; sh_seen = 1'b0; both_seen = 1'b0;
    @(negedge clk);
    cd.vend = 1'b1;
    cd.change_in = c;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      e1_tr[k] = cd.eject_1;
      e2_tr[k] = cd.eject_2;
      dn_tr[k] = cd.done;
      if (cd.done) begin sf_seen = cd.shortfall; sh_seen = cd.short; end
      if (cd.eject_1 & cd.eject_2) both_seen = 1'b1;
      cd.vend = (k == v2_cyc);
      cd.refill_2 = (k == r2_cyc);
      rst = (k == rst_cyc);
    end
    cd.vend = 1'b0;
    cd.refill_2 = 1'b0;
    rst = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp += 8;
    if (cd.eject_1 !== 1'b0) begin $display("FAIL reset_eject_1 got %b want 0", cd.eject_1); n_bad++; end
    if (cd.eject_2 !== 1'b0) begin $display("FAIL reset_eject_2 got %b want 0", cd.eject_2); n_bad++; end
    if (cd.busy !== 1'b0) begin $display("FAIL reset_busy got %b want 0", cd.busy); n_bad++; end
    if (cd.done !== 1'b0) begin $display("FAIL reset_done got %b want 0", cd.done); n_bad++; end
    if (cd.short !== 1'b0 || cd.shortfall !== 3'd0) begin $display("FAIL reset_short got %b/%0d want 0/0", cd.short, cd.shortfall); n_bad++; end
    if (cd.overrun !== 1'b0) begin $display("FAIL reset_overrun got %b want 0", cd.overrun); n_bad++; end
    if (cd.tube1_cnt !== 4'd8) begin $display("FAIL reset_tube1 got %0d want 8", cd.tube1_cnt); n_bad++; end
    if (cd.tube2_cnt !== 4'd8) begin $display("FAIL reset_tube2 got %0d want 8", cd.tube2_cnt); n_bad++; end
    rst = 1'b0;
  endtask
  task automatic test_basic;
    run(3'd3, 20, -1, -1, -1);
    n_cmp += 7;
    if (e2_tr !== 64'h3C) begin $display("FAIL basic_e2 got %h want %h", e2_tr, 64'h3C); n_bad++; end
    if (e1_tr !== 64'h1E00) begin $display("FAIL basic_e1 got %h want %h", e1_tr, 64'h1E00); n_bad++; end
    if (dn_tr !== 64'h10000) begin $display("FAIL basic_done got %h want %h", dn_tr, 64'h10000); n_bad++; end
    if (sf_seen !== 3'd0 || sh_seen !== 1'b0) begin $display("FAIL basic_short got %0d/%b want 0/0", sf_seen, sh_seen); n_bad++; end
    if (cd.tube2_cnt !== 4'd7) begin $display("FAIL basic_tube2 got %0d want 7", cd.tube2_cnt); n_bad++; end
    if (cd.tube1_cnt !== 4'd7) begin $display("FAIL basic_tube1 got %0d want 7", cd.tube1_cnt); n_bad++; end
    if (cd.busy !== 1'b0 || both_seen !== 1'b0) begin $display("FAIL basic_idle busy=%b both=%b want 0/0", cd.busy, both_seen); n_bad++; end
  endtask
  task automatic test_drain;
    run(3'd6, 26, -1, -1, -1);
    n_cmp += 2;
    if (dn_tr !== 64'h1 << 23) begin $display("FAIL drain1_done got %h want %h", dn_tr, 64'h1 << 23); n_bad++; end
    if (cd.tube2_cnt !== 4'd4) begin $display("FAIL drain1_tube2 got %0d want 4", cd.tube2_cnt); n_bad++; end
    run(3'd6, 26, -1, -1, -1);
    run(3'd2, 12, -1, -1, -1);
    n_cmp += 2;
    if (dn_tr !== 64'h200) begin $display("FAIL drain3_done got %h want %h", dn_tr, 64'h200); n_bad++; end
    if (cd.tube2_cnt !== 4'd0) begin $display("FAIL drain3_tube2 got %0d want 0", cd.tube2_cnt); n_bad++; end
    run(3'd6, 48, -1, -1, -1);
    n_cmp += 3;
    if (e2_tr !== 64'h0) begin $display("FAIL fallback_e2 got %h want 0", e2_tr); n_bad++; end
    if (dn_tr !== 64'h1 << 44) begin $display("FAIL fallback_done got %h want %h", dn_tr, 64'h1 << 44); n_bad++; end
    if (cd.tube1_cnt !== 4'd1) begin $display("FAIL fallback_tube1 got %0d want 1", cd.tube1_cnt); n_bad++; end
  endtask
  task automatic test_shortfall;
    run(3'd3, 12, -1, -1, -1);
    n_cmp += 5;
    if (e1_tr !== 64'h3C || e2_tr !== 64'h0) begin $display("FAIL short_ejects got e1=%h e2=%h want 3c/0", e1_tr, e2_tr); n_bad++; end
    if (dn_tr !== 64'h200) begin $display("FAIL short_done got %h want %h", dn_tr, 64'h200); n_bad++; end
    if (sf_seen !== 3'd2 || sh_seen !== 1'b1) begin $display("FAIL short_value got %0d/%b want 2/1", sf_seen, sh_seen); n_bad++; end
    if (cd.shortfall !== 3'd2 || cd.short !== 1'b1) begin $display("FAIL short_hold got %0d/%b want 2/1", cd.shortfall, cd.short); n_bad++; end
    if (cd.tube1_cnt !== 4'd0) begin $display("FAIL short_tube1 got %0d want 0", cd.tube1_cnt); n_bad++; end
  endtask
  task automatic test_ones;
    repeat (8) begin
      @(negedge clk); cd.refill_1 = 1'b1;
      @(negedge clk); cd.refill_1 = 1'b0;
    end
    n_cmp += 1;
    if (cd.tube1_cnt !== 4'd8) begin $display("FAIL refill8_tube1 got %0d want 8", cd.tube1_cnt); n_bad++; end
    run(3'd4, 34, -1, -1, -1);
    n_cmp += 5;
    if (e1_tr !== 64'h78F1E3C) begin $display("FAIL ones_e1 got %h want %h", e1_tr, 64'h78F1E3C); n_bad++; end
    if (e2_tr !== 64'h0) begin $display("FAIL ones_e2 got %h want 0", e2_tr); n_bad++; end
    if (dn_tr !== 64'h40000000) begin $display("FAIL ones_done got %h want %h", dn_tr, 64'h40000000); n_bad++; end
    if (sf_seen !== 3'd0 || sh_seen !== 1'b0) begin $display("FAIL ones_short got %0d/%b want 0/0", sf_seen, sh_seen); n_bad++; end
    if (cd.tube1_cnt !== 4'd4) begin $display("FAIL ones_tube1 got %0d want 4", cd.tube1_cnt); n_bad++; end
  endtask
  task automatic test_zero_and_held;
    int dn_cnt, e1_cnt;
    run(3'd0, 4, -1, -1, -1);
    n_cmp += 2;
    if (dn_tr !== 64'h2) begin $display("FAIL zero_done got %h want 2", dn_tr); n_bad++; end
    if (e1_tr !== 64'h0 || e2_tr !== 64'h0 || sf_seen !== 3'd0) begin $display("FAIL zero_ejects e1=%h e2=%h sf=%0d want 0/0/0", e1_tr, e2_tr, sf_seen); n_bad++; end
    dn_cnt = 0; e1_cnt = 0;
    @(negedge clk); cd.vend = 1'b1; cd.change_in = 3'd1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      dn_cnt += int'(cd.done);
      e1_cnt += int'(cd.eject_1);
      if (k == 20) cd.vend = 1'b0;
    end
    n_cmp += 3;
    if (dn_cnt !== 1) begin $display("FAIL held_done_count got %0d want 1", dn_cnt); n_bad++; end
    if (e1_cnt !== 4) begin $display("FAIL held_eject_cycles got %0d want 4", e1_cnt); n_bad++; end
    if (cd.overrun !== 1'b0 || cd.tube1_cnt !== 4'd3) begin $display("FAIL held_state overrun=%b tube1=%0d want 0/3", cd.overrun, cd.tube1_cnt); n_bad++; end
  endtask
  task automatic test_overrun;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run(3'd3, 20, 1, 4, -1);
    n_cmp += 5;
    if (e2_tr !== 64'h3C || e1_tr !== 64'h1E00) begin $display("FAIL ovr_ejects got e1=%h e2=%h want 1e00/3c", e1_tr, e2_tr); n_bad++; end
    if (dn_tr !== 64'h10000) begin $display("FAIL ovr_done got %h want %h", dn_tr, 64'h10000); n_bad++; end
    if (cd.overrun !== 1'b1) begin $display("FAIL ovr_flag got %b want 1", cd.overrun); n_bad++; end
    if (cd.tube2_cnt !== 4'd8) begin $display("FAIL ovr_refill_collide_tube2 got %0d want 8", cd.tube2_cnt); n_bad++; end
    if (cd.tube1_cnt !== 4'd7 || both_seen !== 1'b0) begin $display("FAIL ovr_tube1 got %0d both=%b want 7/0", cd.tube1_cnt, both_seen); n_bad++; end
  endtask
  task automatic test_saturate;
    repeat (10) begin
      @(negedge clk); cd.refill_1 = 1'b1;
      @(negedge clk); cd.refill_1 = 1'b0;
    end
    n_cmp += 2;
    if (cd.tube1_cnt !== 4'd15) begin $display("FAIL sat_tube1 got %0d want 15", cd.tube1_cnt); n_bad++; end
    if (cd.overrun !== 1'b1) begin $display("FAIL sat_overrun_sticky got %b want 1", cd.overrun); n_bad++; end
  endtask
  task automatic test_rst_mid;
    run(3'd3, 4, -1, -1, 3);
    n_cmp += 4;
    if (e2_tr !== 64'hC) begin $display("FAIL rstmid_e2 got %h want c", e2_tr); n_bad++; end
    if (cd.eject_2 !== 1'b0 || cd.busy !== 1'b0) begin $display("FAIL rstmid_idle eject_2=%b busy=%b want 0/0", cd.eject_2, cd.busy); n_bad++; end
    if (cd.tube1_cnt !== 4'd8 || cd.tube2_cnt !== 4'd8) begin $display("FAIL rstmid_tubes got %0d/%0d want 8/8", cd.tube1_cnt, cd.tube2_cnt); n_bad++; end
    if (cd.overrun !== 1'b0 || cd.done !== 1'b0) begin $display("FAIL rstmid_flags overrun=%b done=%b want 0/0", cd.overrun, cd.done); n_bad++; end
  endtask
  initial begin
    cd.vend = 1'b0; cd.change_in = 3'd0; cd.refill_1 = 1'b0; cd.refill_2 = 1'b0;
    test_reset();
    test_basic();
    test_drain();
    test_shortfall();
    test_ones();
    test_zero_and_held();
    test_overrun();
    test_saturate();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
